// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit.
// The run-cycle counter is enabled by defining FETCH_CYCLE_COUNT_EN.
package fetch_pkg;

   localparam int PC_BITS      = 12;
   localparam int LUT_IDX_BITS = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } fetch_state_e;

   // Absolute branch targets, selected by the instruction's reg1 field
   localparam logic [PC_BITS-1:0] BRANCH_TARGETS [2**LUT_IDX_BITS] = '{
      12'd16,
      12'd32,
      12'd64,
      12'd128,
      12'd4094,
      12'd200,
      12'd1000,
      12'd37
   };

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/status bundle between the decoder side and the fetch PC unit.
// cycle_count exists only when FETCH_CYCLE_COUNT_EN is defined.
interface fetch_pc_unit_if #(
   parameter int PC_BITS      = fetch_pkg::PC_BITS,
   parameter int LUT_IDX_BITS = fetch_pkg::LUT_IDX_BITS
);
   import fetch_pkg::*;

   logic                    start;
   logic                    halt_req;
   logic                    branch_en;
   logic [LUT_IDX_BITS-1:0] branch_idx;
   logic                    stall;
   logic [PC_BITS-1:0]      pc;
   logic                    running;
   logic                    done;
`ifdef FETCH_CYCLE_COUNT_EN
   logic [31:0]             cycle_count;

   modport master (
      output start, halt_req, branch_en, branch_idx, stall,
      input  pc, running, done, cycle_count
   );

   modport slave (
      input  start, halt_req, branch_en, branch_idx, stall,
      output pc, running, done, cycle_count
   );
`else
   modport master (
      output start, halt_req, branch_en, branch_idx, stall,
      input  pc, running, done
   );

   modport slave (
      input  start, halt_req, branch_en, branch_idx, stall,
      output pc, running, done
   );
`endif

endinterface

// File: rtl/fetch_pc_unit_lut.sv
// Combinational branch-target ROM: maps a LUT index to an absolute PC.
module branch_target_lut #(
   parameter int PC_BITS      = fetch_pkg::PC_BITS,
   parameter int LUT_IDX_BITS = fetch_pkg::LUT_IDX_BITS
) (
   input  logic [LUT_IDX_BITS-1:0] idx,
   output logic [PC_BITS-1:0]      target
);
   import fetch_pkg::*;

   assign target = PC_BITS'(BRANCH_TARGETS[idx]);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer (IDLE/RUN/DONE) feeding instruction memory.
// Optional saturating RUN-cycle counter under FETCH_CYCLE_COUNT_EN.
module fetch_pc_unit #(
   parameter int PC_BITS      = fetch_pkg::PC_BITS,
   parameter int LUT_IDX_BITS = fetch_pkg::LUT_IDX_BITS
) (
   input logic            clk,
   input logic            reset,
   fetch_pc_unit_if.slave bus
);
   import fetch_pkg::*;

   fetch_state_e       state;
   logic [PC_BITS-1:0] pc_q;
   logic               running_q;
   logic               done_q;
   logic [PC_BITS-1:0] branch_target;
`ifdef FETCH_CYCLE_COUNT_EN
   logic [31:0]        cycle_cnt;
`endif

   branch_target_lut #(
      .PC_BITS      (PC_BITS),
      .LUT_IDX_BITS (LUT_IDX_BITS)
   ) u_lut (
      .idx    (bus.branch_idx),
      .target (branch_target)
   );

   // Control inputs describe the instruction at the current pc, so the
   // decision taken at this edge picks the address fetched next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pc_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
         cycle_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state     <= RUN;
                  pc_q      <= '0;
                  running_q <= 1'b1;
                  done_q    <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
                  cycle_cnt <= '0;
`endif
               end
            end
            RUN: begin
`ifdef FETCH_CYCLE_COUNT_EN
               if (cycle_cnt != '1) begin
                  cycle_cnt <= cycle_cnt + 32'd1;
               end
`endif
               if (bus.halt_req) begin
                  state     <= DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
               end else if (bus.stall) begin
                  pc_q <= pc_q;
               end else if (bus.branch_en) begin
                  pc_q <= branch_target;
               end else begin
                  pc_q <= pc_q + PC_BITS'(1);
               end
            end
            default: begin
               state     <= IDLE;
               pc_q      <= '0;
               running_q <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc      = pc_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;
`ifdef FETCH_CYCLE_COUNT_EN
   assign bus.cycle_count = cycle_cnt;
`endif

endmodule
